// File: rtl/alu_control_sequencer.sv
// Multi-cycle control sequencer for the 32-bit bus datapath: fetch, decode and
// execute of register/immediate ALU instructions with wait states, pause and halt.
module alu_control_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPCODE_W    = 5,
    parameter int WAIT_STATES = 0,
    parameter int COUNT_W     = 16
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  Stop,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  PCin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic                  Rin,
    output logic                  Rout,
    output logic                  Yin,
    output logic                  Cout,
    output logic [3:0]            AluOp,
    output logic                  Run,
    output logic                  Illegal,
    output logic [COUNT_W-1:0]    InstrCount
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_PAUSE, S_HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(26);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(27);
    localparam logic [3:0]          WAIT_LAST = 4'(WAIT_STATES);

    state_t               state_q;
    logic [3:0]           wait_q;
    logic [3:0]           aluop_q;
    logic                 imm_q;
    logic [COUNT_W-1:0]   count_q;

    logic [OPCODE_W-1:0]  opcode;
    logic                 dec_alu;
    logic                 dec_imm;
    logic [3:0]           dec_aluop;
    logic                 dec_nop;
    logic                 dec_halt;
    logic                 t1_last;
    logic                 unused_ir_bits;

    assign opcode         = IR[DATA_WIDTH-1 -: OPCODE_W];
    assign unused_ir_bits = ^IR[DATA_WIDTH-OPCODE_W-1:0];
    assign t1_last        = (wait_q == WAIT_LAST);
    assign dec_nop        = (opcode == OP_NOP);
    assign dec_halt       = (opcode == OP_HALT);
    assign InstrCount     = count_q;

    always_comb begin
        dec_alu   = 1'b1;
        dec_imm   = 1'b0;
        dec_aluop = 4'b0000;
        case (opcode)
            OP_ADD:  dec_aluop = 4'b0001;
            OP_SUB:  dec_aluop = 4'b0010;
            OP_AND:  dec_aluop = 4'b0100;
            OP_OR:   dec_aluop = 4'b1000;
            OP_ADDI: begin dec_aluop = 4'b0001; dec_imm = 1'b1; end
            OP_ANDI: begin dec_aluop = 4'b0100; dec_imm = 1'b1; end
            OP_ORI:  begin dec_aluop = 4'b1000; dec_imm = 1'b1; end
            default: dec_alu = 1'b0;
        endcase
    end

    // Boundary exits (end of T5, or T3 for nop/illegal) honour Stop only there.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_RESET;
            wait_q  <= 4'd0;
            aluop_q <= 4'd0;
            imm_q   <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_T0;
                S_T0: begin
                    wait_q  <= 4'd0;
                    state_q <= S_T1;
                end
                S_T1: begin
                    if (t1_last) begin
                        wait_q  <= 4'd0;
                        state_q <= S_T2;
                    end else begin
                        wait_q  <= wait_q + 4'd1;
                    end
                end
                S_T2: state_q <= S_T3;
                S_T3: begin
                    if (dec_alu) begin
                        aluop_q <= dec_aluop;
                        imm_q   <= dec_imm;
                        state_q <= S_T4;
                    end else if (dec_halt) begin
                        state_q <= S_HALT;
                    end else begin
                        if (dec_nop) count_q <= count_q + COUNT_W'(1);
                        state_q <= Stop ? S_PAUSE : S_T0;
                    end
                end
                S_T4: state_q <= S_T5;
                S_T5: begin
                    count_q <= count_q + COUNT_W'(1);
                    state_q <= Stop ? S_PAUSE : S_T0;
                end
                S_PAUSE: if (!Stop) state_q <= S_T0;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RESET;
            endcase
        end
    end

    // Strobes decode from state (and IR in T3) so they hold for the full cycle.
    always_comb begin
        PCout   = 1'b0; MARin  = 1'b0; IncPC = 1'b0; Zin  = 1'b0;
        Zlowout = 1'b0; PCin   = 1'b0; Read  = 1'b0; MDRin = 1'b0;
        MDRout  = 1'b0; IRin   = 1'b0; Gra   = 1'b0; Grb  = 1'b0;
        Grc     = 1'b0; Rin    = 1'b0; Rout  = 1'b0; Yin  = 1'b0;
        Cout    = 1'b0; AluOp  = 4'b0000; Run = 1'b0; Illegal = 1'b0;
        case (state_q)
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Read = 1'b1; MDRin = 1'b1;
                Zlowout = t1_last;
                PCin    = t1_last;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (dec_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                Illegal = !dec_alu && !dec_nop && !dec_halt;
            end
            S_T4: begin
                Run   = 1'b1;
                Zin   = 1'b1;
                AluOp = aluop_q;
                Cout  = imm_q;
                Grc   = !imm_q;
                Rout  = !imm_q;
            end
            S_T5: begin
                Run = 1'b1; Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: three instances cover zero/3/2 wait
// states and a 2-bit retire counter.
module tb_alu_control_sequencer;

    localparam int B_PCOUT = 0,  B_MARIN = 1,  B_INCPC = 2,  B_ZIN = 3;
    localparam int B_ZLOW  = 4,  B_PCIN  = 5,  B_READ  = 6,  B_MDRIN = 7;
    localparam int B_MDROUT = 8, B_IRIN  = 9,  B_GRA   = 10, B_GRB = 11;
    localparam int B_GRC   = 12, B_RIN   = 13, B_ROUT  = 14, B_YIN = 15;
    localparam int B_COUT  = 16;

    localparam logic [16:0] S_NONE = 17'd0;
    localparam logic [16:0] S_T0 = (17'd1 << B_PCOUT) | (17'd1 << B_MARIN) | (17'd1 << B_INCPC) | (17'd1 << B_ZIN);
    localparam logic [16:0] S_T1W = (17'd1 << B_READ) | (17'd1 << B_MDRIN);
    localparam logic [16:0] S_T1F = S_T1W | (17'd1 << B_ZLOW) | (17'd1 << B_PCIN);
    localparam logic [16:0] S_T2 = (17'd1 << B_MDROUT) | (17'd1 << B_IRIN);
    localparam logic [16:0] S_T3A = (17'd1 << B_GRB) | (17'd1 << B_ROUT) | (17'd1 << B_YIN);
    localparam logic [16:0] S_T4I = (17'd1 << B_COUT) | (17'd1 << B_ZIN);
    localparam logic [16:0] S_T4R = (17'd1 << B_GRC) | (17'd1 << B_ROUT) | (17'd1 << B_ZIN);
    localparam logic [16:0] S_T5 = (17'd1 << B_ZLOW) | (17'd1 << B_GRA) | (17'd1 << B_RIN);

    localparam logic [31:0] IR_ANDI = 32'h590F_FFFB;
    localparam logic [31:0] IR_SUB  = 32'h2000_0000;
    localparam logic [31:0] IR_ADD  = 32'h1800_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_a = 1'b1, clr_b = 1'b1, clr_c = 1'b1;
    logic        stop_a = 1'b0, stop_b = 1'b0, stop_c = 1'b0;
    logic [31:0] ir_a = 32'd0, ir_b = 32'd0, ir_c = 32'd0;
    logic [16:0] sb_a, sb_b, sb_c;
    logic [3:0]  op_a, op_b, op_c;
    logic        run_a, run_b, run_c, ill_a, ill_b, ill_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    alu_control_sequencer #(.DATA_WIDTH(32), .OPCODE_W(5), .WAIT_STATES(0), .COUNT_W(16)) dut_a (
        .Clock(clk), .Clear(clr_a), .IR(ir_a), .Stop(stop_a),
        .PCout(sb_a[B_PCOUT]), .MARin(sb_a[B_MARIN]), .IncPC(sb_a[B_INCPC]), .Zin(sb_a[B_ZIN]),
        .Zlowout(sb_a[B_ZLOW]), .PCin(sb_a[B_PCIN]), .Read(sb_a[B_READ]), .MDRin(sb_a[B_MDRIN]),
        .MDRout(sb_a[B_MDROUT]), .IRin(sb_a[B_IRIN]), .Gra(sb_a[B_GRA]), .Grb(sb_a[B_GRB]),
        .Grc(sb_a[B_GRC]), .Rin(sb_a[B_RIN]), .Rout(sb_a[B_ROUT]), .Yin(sb_a[B_YIN]),
        .Cout(sb_a[B_COUT]), .AluOp(op_a), .Run(run_a), .Illegal(ill_a), .InstrCount(cnt_a));

    alu_control_sequencer #(.DATA_WIDTH(32), .OPCODE_W(5), .WAIT_STATES(3), .COUNT_W(16)) dut_b (
        .Clock(clk), .Clear(clr_b), .IR(ir_b), .Stop(stop_b),
        .PCout(sb_b[B_PCOUT]), .MARin(sb_b[B_MARIN]), .IncPC(sb_b[B_INCPC]), .Zin(sb_b[B_ZIN]),
        .Zlowout(sb_b[B_ZLOW]), .PCin(sb_b[B_PCIN]), .Read(sb_b[B_READ]), .MDRin(sb_b[B_MDRIN]),
        .MDRout(sb_b[B_MDROUT]), .IRin(sb_b[B_IRIN]), .Gra(sb_b[B_GRA]), .Grb(sb_b[B_GRB]),
        .Grc(sb_b[B_GRC]), .Rin(sb_b[B_RIN]), .Rout(sb_b[B_ROUT]), .Yin(sb_b[B_YIN]),
        .Cout(sb_b[B_COUT]), .AluOp(op_b), .Run(run_b), .Illegal(ill_b), .InstrCount(cnt_b));

    alu_control_sequencer #(.DATA_WIDTH(32), .OPCODE_W(5), .WAIT_STATES(2), .COUNT_W(2)) dut_c (
        .Clock(clk), .Clear(clr_c), .IR(ir_c), .Stop(stop_c),
        .PCout(sb_c[B_PCOUT]), .MARin(sb_c[B_MARIN]), .IncPC(sb_c[B_INCPC]), .Zin(sb_c[B_ZIN]),
        .Zlowout(sb_c[B_ZLOW]), .PCin(sb_c[B_PCIN]), .Read(sb_c[B_READ]), .MDRin(sb_c[B_MDRIN]),
        .MDRout(sb_c[B_MDROUT]), .IRin(sb_c[B_IRIN]), .Gra(sb_c[B_GRA]), .Grb(sb_c[B_GRB]),
        .Grc(sb_c[B_GRC]), .Rin(sb_c[B_RIN]), .Rout(sb_c[B_ROUT]), .Yin(sb_c[B_YIN]),
        .Cout(sb_c[B_COUT]), .AluOp(op_c), .Run(run_c), .Illegal(ill_c), .InstrCount(cnt_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bus_ok(input logic [16:0] sb);
        int n;
        n = int'(sb[B_ZLOW]) + int'(sb[B_MDROUT]) + int'(sb[B_ROUT]) + int'(sb[B_PCOUT]) + int'(sb[B_COUT]);
        return (n <= 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic step_a(input string tag, input logic [16:0] s, input logic r, input logic [3:0] op, input logic il);
        tick();
        check_eq({tag, ".strobes"}, 32'(sb_a), 32'(s));
        check_eq({tag, ".run"}, 32'(run_a), 32'(r));
        check_eq({tag, ".aluop"}, 32'(op_a), 32'(op));
        check_eq({tag, ".illegal"}, 32'(ill_a), 32'(il));
        check_eq({tag, ".bus"}, bus_ok(sb_a), 32'd1);
    endtask

    task automatic step_b(input string tag, input logic [16:0] s, input logic [3:0] op);
        tick();
        check_eq({tag, ".strobes"}, 32'(sb_b), 32'(s));
        check_eq({tag, ".aluop"}, 32'(op_b), 32'(op));
        check_eq({tag, ".run"}, 32'(run_b), 32'd1);
        check_eq({tag, ".bus"}, bus_ok(sb_b), 32'd1);
    endtask

    initial begin
        int runs;
        // Reset state for instance A
        tick();
        check_eq("rst.strobes", 32'(sb_a), 32'd0);
        check_eq("rst.run", 32'(run_a), 32'd0);
        check_eq("rst.count", 32'(cnt_a), 32'd0);
        check_eq("rst.illegal", 32'(ill_a), 32'd0);

        // andi, no wait states
        clr_a = 1'b0; ir_a = IR_ANDI;
        runs = 0;
        step_a("andi.T0", S_T0, 1'b1, 4'b0000, 1'b0);  runs += int'(run_a);
        step_a("andi.T1", S_T1F, 1'b1, 4'b0000, 1'b0); runs += int'(run_a);
        step_a("andi.T2", S_T2, 1'b1, 4'b0000, 1'b0);  runs += int'(run_a);
        step_a("andi.T3", S_T3A, 1'b1, 4'b0000, 1'b0); runs += int'(run_a);
        step_a("andi.T4", S_T4I, 1'b1, 4'b0100, 1'b0); runs += int'(run_a);
        step_a("andi.T5", S_T5, 1'b1, 4'b0000, 1'b0);  runs += int'(run_a);
        check_eq("andi.cnt_before", 32'(cnt_a), 32'd0);
        check_eq("andi.runcycles", 32'(runs), 32'd6);
        step_a("andi.nextT0", S_T0, 1'b1, 4'b0000, 1'b0);
        check_eq("andi.cnt_after", 32'(cnt_a), 32'd1);

        // nop retires after T3
        ir_a = IR_NOP;
        step_a("nop.T1", S_T1F, 1'b1, 4'b0000, 1'b0);
        step_a("nop.T2", S_T2, 1'b1, 4'b0000, 1'b0);
        step_a("nop.T3", S_NONE, 1'b1, 4'b0000, 1'b0);
        step_a("nop.T0", S_T0, 1'b1, 4'b0000, 1'b0);
        check_eq("nop.cnt", 32'(cnt_a), 32'd2);

        // illegal opcode: single Illegal pulse, no retire
        ir_a = IR_ILL;
        step_a("ill.T1", S_T1F, 1'b1, 4'b0000, 1'b0);
        step_a("ill.T2", S_T2, 1'b1, 4'b0000, 1'b0);
        step_a("ill.T3", S_NONE, 1'b1, 4'b0000, 1'b1);
        step_a("ill.T0", S_T0, 1'b1, 4'b0000, 1'b0);
        check_eq("ill.cnt", 32'(cnt_a), 32'd2);

        // Stop raised during T4 takes effect after T5
        ir_a = IR_ANDI;
        step_a("pz.T1", S_T1F, 1'b1, 4'b0000, 1'b0);
        step_a("pz.T2", S_T2, 1'b1, 4'b0000, 1'b0);
        step_a("pz.T3", S_T3A, 1'b1, 4'b0000, 1'b0);
        step_a("pz.T4", S_T4I, 1'b1, 4'b0100, 1'b0);
        stop_a = 1'b1;
        step_a("pz.T5", S_T5, 1'b1, 4'b0000, 1'b0);
        step_a("pz.pause1", S_NONE, 1'b0, 4'b0000, 1'b0);
        check_eq("pz.cnt", 32'(cnt_a), 32'd3);
        step_a("pz.pause2", S_NONE, 1'b0, 4'b0000, 1'b0);
        stop_a = 1'b0;
        step_a("pz.T0", S_T0, 1'b1, 4'b0000, 1'b0);

        // halt, then recover with Clear
        ir_a = IR_HALT;
        step_a("hlt.T1", S_T1F, 1'b1, 4'b0000, 1'b0);
        step_a("hlt.T2", S_T2, 1'b1, 4'b0000, 1'b0);
        step_a("hlt.T3", S_NONE, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step_a("hlt.idle", S_NONE, 1'b0, 4'b0000, 1'b0);
        check_eq("hlt.cnt", 32'(cnt_a), 32'd3);
        clr_a = 1'b1;
        step_a("hlt.reset", S_NONE, 1'b0, 4'b0000, 1'b0);
        check_eq("hlt.cnt_clr", 32'(cnt_a), 32'd0);
        clr_a = 1'b0;
        step_a("hlt.T0", S_T0, 1'b1, 4'b0000, 1'b0);

        // sub with three wait states: 9 cycles
        clr_b = 1'b0; ir_b = IR_SUB;
        step_b("sub.T0", S_T0, 4'b0000);
        step_b("sub.T1a", S_T1W, 4'b0000);
        step_b("sub.T1b", S_T1W, 4'b0000);
        step_b("sub.T1c", S_T1W, 4'b0000);
        step_b("sub.T1d", S_T1F, 4'b0000);
        step_b("sub.T2", S_T2, 4'b0000);
        step_b("sub.T3", S_T3A, 4'b0000);
        step_b("sub.T4", S_T4R, 4'b0010);
        step_b("sub.T5", S_T5, 4'b0000);
        check_eq("sub.cnt_before", 32'(cnt_b), 32'd0);
        step_b("sub.nextT0", S_T0, 4'b0000);
        check_eq("sub.cnt_after", 32'(cnt_b), 32'd1);

        // Clear mid-T1 with two wait states, then 2-bit counter wrap
        clr_c = 1'b0; ir_c = IR_ADD;
        tick();
        check_eq("rc.T0", 32'(sb_c), 32'(S_T0));
        tick();
        check_eq("rc.T1", 32'(sb_c), 32'(S_T1W));
        clr_c = 1'b1;
        tick();
        check_eq("rc.reset.strobes", 32'(sb_c), 32'd0);
        check_eq("rc.reset.run", 32'(run_c), 32'd0);
        check_eq("rc.reset.alu", 32'(op_c), 32'd0);
        clr_c = 1'b0;
        tick();
        check_eq("rc.restartT0", 32'(sb_c), 32'(S_T0));
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 7; c++) begin
                tick();
                if (c == 5) check_eq("wrap.T4alu", 32'(op_c), 32'b0001);
            end
            check_eq("wrap.T5", 32'(sb_c), 32'(S_T5));
            tick();
            check_eq("wrap.cnt", 32'(cnt_c), (k == 3) ? 32'd0 : 32'((k + 1) % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Multi-cycle control unit driving the existing 32-bit bus datapath strobes: fetch (T0–T2), decode (T3) and execute (T4–T5) for register-ALU and immediate-ALU instructions.
- Replaces hand-sequenced control-signal timing with one parametrised FSM.
- Adds memory wait states, NOP/HALT/illegal handling, an instruction-boundary pause and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, width of IR input; opcode occupies IR[DATA_WIDTH-1 -: OPCODE_W]
OPCODE_W, 5, opcode field width
WAIT_STATES, 0, extra cycles T1 is held for memory read (0–15)
COUNT_W, 16, width of InstrCount

Ports:
Clock  in  1  system clock, all state updates on rising edge
Clear  in  1  synchronous active-high reset
IR  in  DATA_WIDTH  current instruction register contents
Stop  in  1  pause request, sampled only at instruction boundaries
PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, Yin, Cout  out  1 each  register-select/bus strobes
AluOp  out  4  one-hot: [0]=ADD [1]=SUB [2]=AND [3]=OR
Run  out  1  high while sequencing
Illegal  out  1  one-cycle pulse on undefined opcode
InstrCount  out  COUNT_W  retired-instruction count

Behaviour:
- Clocking and reset: one clock, Clock. Clear is synchronous, active-high. A rising edge with Clear=1 forces state RESET, clears the wait counter, op latch and InstrCount. All strobes, AluOp, Run and Illegal are 0 in RESET. Clear overrides every other event, including mid-instruction and in HALT.
- States: RESET, T0, T1, T2, T3, T4, T5, PAUSE, HALT. Strobes decode from state (plus IR in T3), so each is valid for the whole cycle.
- RESET -> T0 on the next edge with Clear=0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Read and MDRin for 1+WAIT_STATES cycles. Zlowout and PCin only in the final cycle, so PC loads once. A wait counter counts up to WAIT_STATES. Go to T2.
- T2: MDRout, IRin. Go to T3. IR becomes valid at T3.
- T3: decode opcode combinationally from IR and latch it.
  - Register ALU: add=00011, sub=00100, and=00101, or=00110.
  - Immediate ALU: addi=01010, andi=01011, ori=01100.
  - ALU class: assert Grb, Rout, Yin; go to T4.
  - nop=11010: no strobes; retire; go to T0/PAUSE.
  - halt=11011: no strobes; go to HALT.
  - Any other opcode: Illegal=1 this cycle, no strobes, no retire; go to T0/PAUSE.
- T4: AluOp one-hot from the latched op, plus Zin.
  - Register class also asserts Grc and Rout.
  - Immediate class also asserts Cout.
  - Go to T5.
- T5: Zlowout, Gra, Rin. Retire. Go to T0/PAUSE.
- Instruction boundary (end of T5, or T3 for nop/illegal): if Stop=1 go to PAUSE, else T0.
- PAUSE: Run=0, all strobes 0. Stays while Stop=1; returns to T0 on the edge after Stop=0.
- HALT: Run=0, all strobes 0. Stays until Clear.
- Run=1 in T0–T5, 0 in RESET, PAUSE and HALT.
- Retire: InstrCount increments by 1 on the edge leaving T5 or leaving T3 for nop. It wraps from all-ones to 0 silently. It does not increment for halt or illegal.
- Stop asserted mid-instruction has no effect until the boundary.
- At most one of Zlowout/MDRout/Rout/PCout/Cout is high in any cycle (bus exclusivity invariant).
- Opcode comparisons use exactly OPCODE_W bits; opcode values above are for OPCODE_W=5.

Test Plan:
- Immediate ALU, WAIT_STATES=0: IR=32'h590FFFFB (andi), Stop=0 -> exactly 6 Run cycles T0..T5. T3 asserts Grb+Rout+Yin. T4 asserts Cout+Zin+AluOp=4'b0100. T5 asserts Zlowout+Gra+Rin. InstrCount 0->1. Bus-exclusivity holds every cycle.
- Register ALU with wait: WAIT_STATES=3, IR opcode 00100 (sub) -> T1 lasts 4 cycles. Read/MDRin high all 4. PCin/Zlowout high only in the 4th. T4 asserts Grc+Rout+Zin+AluOp=4'b0010. Total 9 cycles per instruction.
- Nop then illegal: opcode 11010 -> back to T0 after T3, count+1. Opcode 11111 -> Illegal pulses exactly one cycle in T3, no strobes, count unchanged.
- Halt and recovery: opcode 11011 -> HALT, Run=0 for 20 cycles with all strobes 0. Clear=1 one cycle -> RESET with InstrCount=0, then T0.
- Pause: Stop=1 raised during T4 -> T5 completes, then PAUSE with Run=0. Stop=0 -> T0 one edge later.
- Reset mid-operation and wrap: Clear during T1 with WAIT_STATES=2 -> RESET next edge, all outputs 0, restart at T0. With COUNT_W=2, retire 5 instructions -> InstrCount sequence 1,2,3,0,1.
